dfr_mem_arbiter: RTL and testbench

DFR_MEM_ARBITER -- requirements
Module: dfr_mem_arbiter

---
 rtl/dfr_pkg.sv | 18 +
 rtl/dfr_prio_pick.sv | 33 +++
 rtl/dfr_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dfr_mem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dfr_pkg.sv
// Shared arbiter types: FSM states, requester indices and index-width helper.
// Optional round-robin arbitration is enabled by DFR_ARB_ROUND_ROBIN_EN.
package dfr_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int REQ_RES_WR = 0;
  localparam int REQ_MM_RD  = 1;
  localparam int REQ_HOST   = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dfr_prio_pick.sv
// Circular priority picker: first eligible request at or after start_i.
// Eligible means requested and not masked; result is one-hot or zero.
module dfr_prio_pick
  import dfr_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o
);

  logic [N-1:0] elig;

  assign elig = req_i & ~mask_i;

  // Walk farthest-to-nearest so the nearest eligible index wins.
  always_comb begin
    int s;
    s     = 0;
    gnt_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = (int'(start_i) + k) % N;
      if (elig[s]) begin
        gnt_o    = '0;
        gnt_o[s] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dfr_mem_arbiter.sv
// Single-port BRAM arbiter with lockable bursts and burst-length fairness.
// Define DFR_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module dfr_mem_arbiter
  import dfr_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_din,
  input  logic [DATA_WIDTH-1:0]         mem_dout,
  output logic                          locked
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE  = CW'(1);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      start;
  logic               hold;

`ifdef DFR_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  assign start = rr_ptr_q;

  // Round-robin pointer: one past the last requester won in arbitration.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rr_ptr_q <= '0;
    else                rr_ptr_q <= rr_ptr_d;
  end
`else
  assign start = '0;
`endif

  dfr_prio_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .mask_i  (mask_q),
    .start_i (start),
    .gnt_o   (pick_gnt)
  );

  // Encode the picked one-hot grant as an index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_gnt[i]) pick_idx = IW'(i);
  end

  assign hold = (state_q == LOCKED) && req[owner_q] &&
                lock[owner_q] && (cnt_q < CMAX);

  // Grant and next-state: owner keeps the port, else arbitrate fresh.
  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    cnt_d   = '0;
    mask_d  = '0;
    gnt     = '0;
`ifdef DFR_ARB_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
`endif
    if (hold) begin
      gnt[owner_q] = 1'b1;
      if ((cnt_q + ONE) >= CMAX) begin
        mask_d = gnt;
      end else begin
        state_d = LOCKED;
        cnt_d   = cnt_q + ONE;
      end
    end else if (|pick_gnt) begin
      gnt = pick_gnt;
`ifdef DFR_ARB_ROUND_ROBIN_EN
      if (pick_idx == IW'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                              rr_ptr_d = pick_idx + IW'(1);
`endif
      if (lock[pick_idx]) begin
        owner_d = pick_idx;
        if (MAX_BURST <= 1) begin
          mask_d = pick_gnt;
        end else begin
          state_d = LOCKED;
          cnt_d   = ONE;
        end
      end
    end
  end

  // Route the granted requester's slice onto the BRAM port.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_din  = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        mem_we   = we[i];
      end
    end
  end

  assign mem_en = |gnt;
  assign rvalid = rvalid_q;
  assign rdata  = mem_dout;
  assign locked = (state_q == LOCKED);

  // Arbiter state and one-cycle-delayed read strobes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      rvalid_q <= gnt & ~we;
    end
  end

endmodule

// File: tb/tb_dfr_mem_arbiter.sv
// Directed bench for dfr_mem_arbiter with a behavioural 1-cycle BRAM.
// Expected grant order follows DFR_ARB_ROUND_ROBIN_EN when defined.
module tb_dfr_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0, lock = '0, we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, mem_din, mem_dout;
  logic            mem_en, mem_we, locked;
  logic [AW-1:0]   mem_addr;

  logic [DW-1:0]   mem [0:(1<<AW)-1];

  int n_chk = 0;
  int n_fail = 0;

  dfr_mem_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(16)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .req           (req),
    .lock          (lock),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      else        mem_dout <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [N-1:0] exp_g [4];
    int n2;

    mem[5] = 32'hDEADBEEF;
`ifdef DFR_ARB_ROUND_ROBIN_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b010;
    exp_g[2] = 3'b100; exp_g[3] = 3'b001;
`else
    exp_g[0] = 3'b001; exp_g[1] = 3'b001;
    exp_g[2] = 3'b001; exp_g[3] = 3'b001;
`endif

    // reset state
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_locked", locked, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // all requesting, no lock
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb_gnt", gnt, exp_g[i]);
      chk("arb_locked", locked, 0);
      if (i > 0) chk("arb_rvalid", rvalid, exp_g[i-1]);
      tick();
    end
    req = '0;
    #1;
    chk("arb_rvalid_last", rvalid, exp_g[3]);
    chk("arb_idle_gnt", gnt, 0);
    tick();
    chk("arb_rvalid_clr", rvalid, 0);

    // requester 1 reads preloaded word
    req = 3'b010;
    addr[1*AW +: AW] = 14'h0005;
    #1;
    chk("rd_gnt", gnt, 3'b010);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_addr", mem_addr, 14'h0005);
    chk("rd_mem_we", mem_we, 0);
    tick();
    req = '0;
    #1;
    chk("rd_rvalid", rvalid, 3'b010);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    tick();
    chk("rd_rvalid_clr", rvalid, 0);

    // requester 0 writes then reads back top address
    req = 3'b001;
    we = 3'b001;
    addr[0 +: AW] = 14'h3FFF;
    wdata[0 +: DW] = 32'h12345678;
    #1;
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 14'h3FFF);
    chk("wr_mem_din", mem_din, 32'h12345678);
    tick();
    chk("wr_no_rvalid", rvalid, 0);
    we = '0;
    #1;
    chk("rb_mem_we", mem_we, 0);
    chk("rb_gnt", gnt, 3'b001);
    tick();
    req = '0;
    #1;
    chk("rb_rvalid", rvalid, 3'b001);
    chk("rb_rdata", rdata, 32'h12345678);
    tick();

    // requester 2 burst, requester 0 waiting
    req = 3'b100;
    lock = 3'b100;
    addr[2*AW +: AW] = 14'h0005;
    #1;
    chk("bst_first_gnt", gnt, 3'b100);
    chk("bst_first_locked", locked, 0);
    tick();
    req = 3'b101;
    chk("bst_locked", locked, 1);
    n2 = 1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (gnt !== 3'b100) break;
      n2++;
      tick();
    end
    chk("bst_count", n2, 16);
    chk("bst_handoff_gnt", gnt, 3'b001);
    chk("bst_unlocked", locked, 0);
    tick();
    req = 3'b100;
    #1;
    chk("bst_relock_gnt", gnt, 3'b100);
    tick();
    req = '0;
    lock = '0;
    tick();
    tick();

    // reset mid-burst at burst count 7 with a read pending
    req = 3'b100;
    lock = 3'b100;
    repeat (7) tick();
    chk("mid_locked", locked, 1);
    chk("mid_rvalid", rvalid, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rvalid", rvalid, 0);
    chk("post_locked", locked, 0);
    chk("post_gnt", gnt, 3'b100);
    n2 = 0;
    for (int c = 0; c < 40; c++) begin
      if (gnt !== 3'b100) break;
      n2++;
      tick();
      req = 3'b101;
      #1;
    end
    chk("post_count", n2, 16);
    chk("post_handoff_gnt", gnt, 3'b001);
    chk("post_unlocked", locked, 0);
    req = '0;
    lock = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
